// File: rtl/ucdp_clk_sel_pkg.sv
// Shared types and constants for the clock-select sequencer.
package ucdp_clk_sel_pkg;

  localparam int cnt_width_p = 8;

  typedef enum logic {
    sel_a_e = 1'b0,
    sel_b_e = 1'b1
  } sel_e;

  typedef enum logic [2:0] {
    IDLE,
    OFF,
    SWITCH,
    ON,
    DONE
  } state_e;

endpackage

// File: rtl/ucdp_clk_sel_cnt.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
module ucdp_clk_sel_cnt
  import ucdp_clk_sel_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [cnt_width_p-1:0] load_val_i,
  input  logic                   en_i,
  output logic                   zero_o
);

  localparam logic [cnt_width_p-1:0] one_c = cnt_width_p'(1);

  logic [cnt_width_p-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - one_c;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ucdp_clk_sel_ctrl.sv
// Sequences a safe clka/clkb switch: gate off, settle, change select, settle, gate on.
module ucdp_clk_sel_ctrl
  import ucdp_clk_sel_pkg::*;
#(
  parameter int   OFF_CYCLES = 4,
  parameter int   ON_CYCLES  = 4,
  parameter logic SEL_RST    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  output logic req_ready_o,
  input  logic req_sel_i,
  output logic sel_o,
  output logic clk_en_o,
  output logic busy_o,
  output logic done_o
);

  localparam logic [cnt_width_p-1:0] off_load_c = cnt_width_p'(OFF_CYCLES - 1);
  localparam logic [cnt_width_p-1:0] on_load_c  = cnt_width_p'(ON_CYCLES - 1);

  state_e state_q, state_d;
  sel_e   sel_q, req_sel_q;
  logic   clk_en_q, busy_q, done_q, ready_q;
  logic   accept;
  logic   cnt_load, cnt_en, cnt_zero;
  logic [cnt_width_p-1:0] cnt_val;

  assign accept = req_valid_i & ready_q;

  ucdp_clk_sel_cnt u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = off_load_c;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_e'(req_sel_i) == sel_q) begin
            state_d = DONE;
          end else begin
            state_d  = OFF;
            cnt_load = 1'b1;
          end
        end
      end
      OFF: begin
        if (cnt_zero) state_d = SWITCH;
        else          cnt_en  = 1'b1;
      end
      SWITCH: begin
        state_d  = ON;
        cnt_load = 1'b1;
        cnt_val  = on_load_c;
      end
      ON: begin
        if (cnt_zero) state_d = DONE;
        else          cnt_en  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are flop-driven
  // yet line up with the state they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sel_q     <= sel_e'(SEL_RST);
      req_sel_q <= sel_e'(SEL_RST);
      clk_en_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) req_sel_q <= sel_e'(req_sel_i);
      if (state_d == SWITCH) sel_q <= req_sel_q;
      clk_en_q <= !((state_d == OFF) || (state_d == SWITCH) || (state_d == ON));
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
      ready_q  <= (state_d == IDLE);
    end
  end

  assign sel_o       = sel_q;
  assign clk_en_o    = clk_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign req_ready_o = ready_q;

endmodule

// File: tb/tb_ucdp_clk_sel_ctrl.sv
// Two sequencer instances (4/4 and 1/1 settle times) checked against a latency-timeline model.
module tb_ucdp_clk_sel_ctrl;

  localparam int N = 2;

  int   off_c [N] = '{4, 1};
  int   on_c  [N] = '{4, 1};
  logic rst_val[N] = '{1'b0, 1'b1};

  logic clk_i = 1'b0;
  logic rst_i;
  logic req_valid[N], req_sel[N];
  logic ready_w[N], sel_w[N], en_w[N], busy_w[N], done_w[N];

  always #5 clk_i = ~clk_i;

  ucdp_clk_sel_ctrl #(.OFF_CYCLES(4), .ON_CYCLES(4), .SEL_RST(1'b0)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid[0]), .req_ready_o(ready_w[0]), .req_sel_i(req_sel[0]),
    .sel_o(sel_w[0]), .clk_en_o(en_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0])
  );

  ucdp_clk_sel_ctrl #(.OFF_CYCLES(1), .ON_CYCLES(1), .SEL_RST(1'b1)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid[1]), .req_ready_o(ready_w[1]), .req_sel_i(req_sel[1]),
    .sel_o(sel_w[1]), .clk_en_o(en_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position t within the current request's timeline (t = 1 is the
  // cycle after acceptance), total length len, and whether the select differs.
  bit   in_seq[N];
  int   t_m[N], len_m[N];
  bit   diff_m[N];
  logic sel_m[N], tgt_m[N];

  task automatic check(input string tag, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      in_seq[i] = 1'b0;
      t_m[i]    = 0;
      sel_m[i]  = rst_val[i];
      tgt_m[i]  = rst_val[i];
    end
  endtask

  task automatic check_cycle(input int i);
    logic e_ready, e_busy, e_done, e_en, e_sel;
    e_ready = !in_seq[i];
    e_busy  = in_seq[i];
    e_done  = in_seq[i] && (t_m[i] == len_m[i]);
    e_en    = !(in_seq[i] && diff_m[i] && (t_m[i] < len_m[i]));
    e_sel   = (in_seq[i] && diff_m[i] && (t_m[i] >= off_c[i] + 1)) ? tgt_m[i] : sel_m[i];
    check($sformatf("d%0d_ready", i), ready_w[i], e_ready);
    check($sformatf("d%0d_busy", i),  busy_w[i],  e_busy);
    check($sformatf("d%0d_done", i),  done_w[i],  e_done);
    check($sformatf("d%0d_clk_en", i), en_w[i],   e_en);
    check($sformatf("d%0d_sel", i),   sel_w[i],   e_sel);
  endtask

  task automatic advance(input int i);
    if (in_seq[i]) begin
      if (t_m[i] == len_m[i]) begin
        in_seq[i] = 1'b0;
        sel_m[i]  = tgt_m[i];
      end else begin
        t_m[i]++;
      end
    end else if (req_valid[i] && !rst_i) begin
      in_seq[i] = 1'b1;
      t_m[i]    = 1;
      tgt_m[i]  = req_sel[i];
      diff_m[i] = (req_sel[i] != sel_m[i]);
      len_m[i]  = diff_m[i] ? off_c[i] + on_c[i] + 2 : 1;
    end
  endtask

  // One cycle: check outputs mid-cycle, then drive this cycle's inputs and advance the model.
  task automatic step(input logic v0, input logic s0, input logic v1, input logic s1);
    @(negedge clk_i);
    for (int i = 0; i < N; i++) check_cycle(i);
    req_valid[0] = v0; req_sel[0] = s0;
    req_valid[1] = v1; req_sel[1] = s1;
    for (int i = 0; i < N; i++) advance(i);
  endtask

  initial begin
    rst_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_sel[i]   = 1'b0;
    end
    model_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_i = 1'b0;

    // Differing select on the 4/4 unit, same select on the 1/1 unit.
    step(1, 1, 1, 1);
    for (int k = 0; k < 12; k++) step(0, 0, 0, 0);

    // Same select on the 4/4 unit, differing select on the 1/1 unit.
    step(1, 1, 1, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0);

    // Reset during cycle 3 of a switch must clear outputs without a clock edge.
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    #2 rst_i = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("d%0d_async_clk_en", i), en_w[i],   1'b1);
      check($sformatf("d%0d_async_sel", i),    sel_w[i],  rst_val[i]);
      check($sformatf("d%0d_async_busy", i),   busy_w[i], 1'b0);
      check($sformatf("d%0d_async_done", i),   done_w[i], 1'b0);
      check($sformatf("d%0d_async_ready", i),  ready_w[i], 1'b1);
    end
    model_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_i = 1'b0;

    // Requests held valid with the select toggling every cycle.
    for (int k = 0; k < 60; k++) begin
      logic b;
      b = k[0];
      step(1, b, 1, ~b);
    end

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom));
    end
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
